// File: rtl/exp_job_sequencer.sv
// exp_job_sequencer: valid/ready wrapper around the start/done exponential core.
// It buffers x samples in a FIFO, runs one core job at a time and holds each result in a one-entry output register.
// Optional build macro EXP_SEQ_WATCHDOG_EN adds a sticky watchdog for the core's done handshake.
module exp_job_sequencer #(
    parameter int DEPTH          = 4,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_result,
    output logic        core_start,
    output logic [15:0] core_x,
    input  logic        core_done,
    input  logic [17:0] core_result,
    output logic        busy,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [LW-1:0] LAST_LAUNCH = LW'(START_CYCLES - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (START_CYCLES < 1) begin : g_bad_start
        $error("START_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LOW,
        WAIT_HIGH,
        CAPTURE
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [LW-1:0]   launch_cnt;
    logic            push, pop, full, empty;
    logic            launch_last, out_free, waiting, timeout;

    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign in_ready    = !full;
    assign push        = in_valid && in_ready;
    assign launch_last = (launch_cnt == LAST_LAUNCH);
    assign pop         = (state == LAUNCH) && launch_last;
    assign out_free    = !out_valid || out_ready;
    assign waiting     = (state == WAIT_LOW) || (state == WAIT_HIGH);

    assign core_start  = (state == LAUNCH);
    assign core_x      = mem[rd_ptr];
    assign busy        = (state != IDLE);

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage array has no reset; occupancy is tracked by count, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!empty && core_done && out_free) state_nxt = LAUNCH;
            LAUNCH:    if (launch_last) state_nxt = WAIT_LOW;
            WAIT_LOW:  if (!core_done) state_nxt = WAIT_HIGH;
            WAIT_HIGH: if (core_done) state_nxt = CAPTURE;
            CAPTURE:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            launch_cnt <= '0;
        end else if (state == LAUNCH && !launch_last) begin
            launch_cnt <= launch_cnt + 1'b1;
        end else begin
            launch_cnt <= '0;
        end
    end

    // A capture cannot coincide with a consumer clear: launches only start with the register free.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (state == CAPTURE) begin
            out_valid  <= 1'b1;
            out_result <= core_result;
        end else if (timeout) begin
            out_valid  <= 1'b1;
            out_result <= '1;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef EXP_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wd_cnt;
    logic          err_q;

    // Fires on the wait cycle in which the counter would reach TIMEOUT_CYCLES.
    assign timeout = waiting && (wd_cnt == WD_LAST);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (pop) begin
                wd_cnt <= '0;
            end else if (waiting) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
    logic unused_waiting;
    assign unused_waiting = waiting;
`endif

endmodule

// File: tb/tb_exp_job_sequencer.sv
// Bench for exp_job_sequencer: behavioural stub core plus a result scoreboard.
// Build with EXP_SEQ_WATCHDOG_EN defined to exercise the watchdog path instead of the indefinite wait.
module tb_exp_job_sequencer;

    localparam int DEPTH        = 4;
    localparam int START_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_x;
    logic        out_valid, out_ready;
    logic [17:0] out_result;
    logic        core_start, core_done;
    logic [15:0] core_x;
    logic [17:0] core_result;
    logic        busy, err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exp_job_sequencer #(
        .DEPTH(DEPTH),
        .START_CYCLES(START_CYCLES),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .core_start(core_start),
        .core_x(core_x),
        .core_done(core_done),
        .core_result(core_result),
        .busy(busy),
        .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stub core: done drops one cycle after start falls, rises 10 cycles later, result = x + 1.
    logic        stub_done, start_q, force_low, never_rise;
    logic [15:0] x_lat;
    logic [17:0] stub_res;
    int          stub_cnt;

    assign core_done   = stub_done && !force_low;
    assign core_result = stub_res;

    always @(posedge clk) begin
        if (rst) begin
            stub_done <= 1'b1;
            start_q   <= 1'b0;
            stub_cnt  <= 0;
            stub_res  <= '0;
            x_lat     <= '0;
        end else begin
            start_q <= core_start;
            if (core_start) x_lat <= core_x;
            if (start_q && !core_start) begin
                stub_done <= 1'b0;
                stub_cnt  <= 10;
                stub_res  <= {2'b00, x_lat} + 18'd1;
            end else if (!stub_done && !never_rise) begin
                if (stub_cnt == 1) stub_done <= 1'b1;
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // Scoreboard: expected result queued at input handshake, compared at output handshake.
    logic [17:0] exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back({2'b00, in_x} + 18'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 32'(out_result), 32'h0);
                else check("result", 32'(out_result), 32'(exp_q.pop_front()));
            end
        end
    end

    int          start_run = 0;
    int          launches  = 0;
    logic [15:0] x_at_start;

    always @(negedge clk) begin
        if (rst) begin
            start_run = 0;
        end else if (core_start) begin
            if (start_run == 0) x_at_start = core_x;
            else check("core_x_stable", 32'(core_x), 32'(x_at_start));
            start_run++;
        end else if (start_run != 0) begin
            check("start_len", start_run, START_CYCLES);
            start_run = 0;
            launches++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] x);
        int t = 0;
        in_valid = 1'b1;
        in_x     = x;
        while (!in_ready && t < 300) begin
            step(1);
            t++;
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'h1);
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && t < budget) begin
            step(1);
            t++;
        end
        if (exp_q.size() != 0 || busy || out_valid) check("drain_timeout", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int l0;
        int t;
        in_valid   = 1'b0;
        in_x       = '0;
        out_ready  = 1'b0;
        force_low  = 1'b0;
        never_rise = 1'b0;
        rst        = 1'b1;
        step(2);
        rst = 1'b0;

        check("rst_in_ready",   32'(in_ready),   32'h1);
        check("rst_out_valid",  32'(out_valid),  32'h0);
        check("rst_out_result", 32'(out_result), 32'h0);
        check("rst_core_start", 32'(core_start), 32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_err",        32'(err),        32'h0);

        // Single job with one-cycle launch latency.
        out_ready = 1'b1;
        l0 = launches;
        push(16'h0000);
        check("latency_pre", 32'(core_start), 32'h0);
        step(1);
        check("latency_start", 32'(core_start), 32'h1);
        wait_idle(100);
        check("t1_launches", launches - l0, 1);
        check("t1_result_hold", 32'(out_result), 32'h1);
        check("t1_in_ready", 32'(in_ready), 32'h1);

        // Back-to-back samples, results in order.
        l0 = launches;
        for (int i = 1; i <= 4; i++) push(16'(i));
        wait_idle(300);
        check("t2_launches", launches - l0, 4);
        check("t2_last_result", 32'(out_result), 32'h5);

        // Output back-pressure fills the FIFO.
        out_ready = 1'b0;
        l0 = launches;
        for (int i = 0; i < 5; i++) push(16'h10 + 16'(i));
        in_valid = 1'b1;
        in_x     = 16'h15;
        step(40);
        check("bp_in_ready", 32'(in_ready), 32'h0);
        check("bp_out_valid", 32'(out_valid), 32'h1);
        check("bp_out_result", 32'(out_result), 32'h11);
        check("bp_launches", launches - l0, 1);
        check("bp_busy", 32'(busy), 32'h0);
        out_ready = 1'b1;
        push(16'h15);
        wait_idle(500);
        check("bp_drained_launches", launches - l0, 6);
        check("bp_last_result", 32'(out_result), 32'h16);

        // Reset while waiting for done to rise.
        push(16'h0100);
        t = 0;
        while (!(busy && !core_done && !core_start) && t < 50) begin
            step(1);
            t++;
        end
        check("reach_wait", 32'(busy && !core_done), 32'h1);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_out_valid",  32'(out_valid),  32'h0);
        check("mid_rst_busy",       32'(busy),       32'h0);
        check("mid_rst_in_ready",   32'(in_ready),   32'h1);
        check("mid_rst_core_start", 32'(core_start), 32'h0);
        push(16'h0200);
        wait_idle(100);
        check("post_rst_result", 32'(out_result), 32'h201);

        // Core externally busy at launch time.
        force_low = 1'b1;
        l0 = launches;
        push(16'h0007);
        step(20);
        check("held_core_start", 32'(core_start), 32'h0);
        check("held_busy", 32'(busy), 32'h0);
        check("held_launches", launches - l0, 0);
        force_low = 1'b0;
        step(1);
        check("release_launch", 32'(core_start), 32'h1);
        wait_idle(100);
        check("release_result", 32'(out_result), 32'h8);

        // Core never re-raises done.
        never_rise = 1'b1;
        out_ready  = 1'b0;
        push(16'h0009);
`ifdef EXP_SEQ_WATCHDOG_EN
        t = 0;
        while (!out_valid && t < 400) begin
            step(1);
            t++;
        end
        check("wd_out_valid", 32'(out_valid), 32'h1);
        check("wd_err", 32'(err), 32'h1);
        check("wd_result", 32'(out_result), 32'h3FFFF);
        if (exp_q.size() != 0) exp_q[0] = 18'h3FFFF;
        out_ready = 1'b1;
        step(2);
        check("wd_err_sticky", 32'(err), 32'h1);
`else
        t = 0;
        repeat (1000) begin
            step(1);
            if (out_valid || err) t++;
        end
        check("no_wd_quiet", t, 0);
        check("no_wd_busy", 32'(busy), 32'h1);
`endif
        rst = 1'b1;
        step(1);
        rst        = 1'b0;
        never_rise = 1'b0;
        check("final_err", 32'(err), 32'h0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exp_job_sequencer.md
Name: exp_job_sequencer

Overview:
- Wraps the start/done exponential series core (16-bit x in, 18-bit result out) with valid/ready streaming on both sides.
- Buffers incoming x samples in a small FIFO and launches one core job at a time.
- Holds start for the core's load window, then tracks the core's done low-then-high sequence.
- Captures the result into a one-entry output register. Sits directly upstream and downstream of the core, between the sample source and the result consumer.

Parameters:
- DEPTH, 4, input FIFO entries; power of two, ≥2.
- START_CYCLES, 2, cycles core_start is held high per launch; ≥1.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  x sample offered.
- in_ready  out  1  FIFO not full.
- in_x  in  16  sample, unsigned Q0.16.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts result.
- out_result  out  18  captured core result.
- core_start  out  1  start to core.
- core_x  out  16  x to core; driven from FIFO head.
- core_done  in  1  core done; high when core is idle.
- core_result  in  18  core result bus.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky watchdog flag; constant 0 without the optional feature.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - FIFO empty; in_ready=1.
  - out_valid=0, out_result=0.
  - core_start=0, busy=0, err=0.
  - FSM state IDLE; all counters cleared.
  - Reset mid-job abandons the job and any FIFO contents. The core is reset by its own rst.
- Input FIFO:
  - Push on in_valid&in_ready.
  - Pop exactly once per job, on the LAUNCH→WAIT_LOW transition.
  - Push and pop in the same cycle when full: the push is refused, because in_ready reflects the registered full state.
  - Pointers wrap modulo DEPTH. The count is kept in a log2(DEPTH)+1-bit counter.
- core_x always equals the FIFO head entry. It is stable throughout LAUNCH because no pop occurs there.
- FSM states:
  - IDLE:
    - Go to LAUNCH when FIFO non-empty, core_done=1, and out_valid=0 (or out_valid&out_ready this cycle).
    - Otherwise stay.
  - LAUNCH:
    - core_start=1 for START_CYCLES cycles, counted by the launch counter.
    - On the last cycle, pop the FIFO and go to WAIT_LOW.
  - WAIT_LOW:
    - core_start=0.
    - Go to WAIT_HIGH when core_done=0.
  - WAIT_HIGH:
    - Go to CAPTURE when core_done=1.
  - CAPTURE:
    - Load out_result←core_result and set out_valid=1.
    - Go to IDLE.
- Output register:
  - out_valid clears on out_valid&out_ready.
  - out_result holds its value until the next CAPTURE.
  - A same-cycle clear and CAPTURE cannot occur, because launch requires the register to be free.
- Latency: in_x accepted into an empty FIFO with the sequencer idle → core_start high 1 cycle later. CAPTURE → out_valid visible 1 cycle later.
- Back-pressure:
  - At most one result is outstanding.
  - While out_valid=1 and out_ready=0, no new job launches and the FIFO keeps filling.
  - in_ready drops at DEPTH entries.
- If core_done is 0 in IDLE (core externally busy), launch waits.

Optional Feature:
- Macro: EXP_SEQ_WATCHDOG_EN.
- When defined:
  - A counter clears on entry to WAIT_LOW and increments each cycle in WAIT_LOW or WAIT_HIGH.
  - When it reaches TIMEOUT_CYCLES: err is set (sticky until rst), out_result←18'h3FFFF, out_valid=1, and the FSM goes to IDLE.
  - The job is consumed and counts as completed.
- When undefined: no counter is built, err is tied 0, and the FSM waits indefinitely.

Test Plan:
- Real core attached; push x=16'h0000; out_ready=1 → exactly one out_valid pulse with out_result=18'h0FFFF; busy returns 0; FIFO empty.
- Stub core (done drops 1 cycle after start falls, rises 10 cycles later, result=x+1). Push x=1,2,3,4 back-to-back → out_result sequence 2,3,4,5 in order; core_start high exactly START_CYCLES=2 cycles per job; core_x stable while core_start=1.
- Stub core, out_ready=0: push 6 samples → in_ready=0 after 4 FIFO entries plus 1 captured; no second launch until out_ready=1; then results drain in order, none lost.
- Assert rst for 1 cycle while in WAIT_HIGH → next cycle: out_valid=0, busy=0, in_ready=1, core_start=0; a new push then completes normally.
- Stub core holds core_done=0 at start → launch waits; core_start stays 0 until done=1.
- With EXP_SEQ_WATCHDOG_EN: stub never re-raises done → after 255 cycles, err=1 and out_result=18'h3FFFF with out_valid=1. Without the macro: out_valid stays 0 and err stays 0 for 1000 cycles.
